// File: rtl/seq_det_pkg.sv
// Shared types for the sequence-detector scheduler: FSM state encoding and the reset pattern.
package seq_det_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, REPORT} state_t;
    localparam logic [3:0] DEFAULT_PATTERN = 4'b1101;
endpackage

// File: rtl/pat_det_moore.sv
// Serial pattern detector with a registered (Moore) match output, one cycle after the closing bit.
module pat_det_moore #(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    input  logic [PAT_W-1:0] pattern,
    output logic             match
);
    localparam int FILL_W = $clog2(PAT_W + 1);

    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              match_q, match_d;

    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        match_d = 1'b0;
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (en) begin
            hist_d = (hist_q << 1) | PAT_W'(din);
            if (fill_q != FILL_W'(PAT_W)) fill_d = fill_q + 1'b1;
            // The fill guard keeps a partly filled history from matching an all-zero pattern.
            match_d = (fill_d == FILL_W'(PAT_W)) && (hist_d == pattern);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
        end
    end

    assign match = match_q;
endmodule

// File: rtl/seq_det_scheduler.sv
// Round-robin scheduler that serialises one granted frame at a time through a shared pattern detector
// and reports the saturating overlapping-match count with the requester id.
module seq_det_scheduler
    import seq_det_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int FRAME_W = 8,
    parameter int PAT_W   = 4,
    parameter int CNT_W   = 3,
    localparam int ID_W   = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*FRAME_W-1:0] frame,
    output logic [NREQ-1:0]         gnt,
    input  logic                    cfg_we,
    input  logic [PAT_W-1:0]        cfg_pattern,
    output logic                    busy,
    output logic                    done,
    output logic [ID_W-1:0]         done_id,
    output logic [CNT_W-1:0]        match_cnt
);
    localparam int BC_W = $clog2(FRAME_W + 1);

    state_t             state_q, state_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [ID_W-1:0]    done_id_q, done_id_d;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [BC_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PAT_W-1:0]   pattern_q, pattern_d;

    logic [FRAME_W-1:0] frame_arr [NREQ];
    logic [ID_W-1:0]    win, idx;
    logic               found;
    logic               det_clr, det_en, det_match;
    logic [CNT_W-1:0]   cnt_inc;

    // First requesting id at or above the rr pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            frame_arr[i] = frame[i*FRAME_W +: FRAME_W];
            idx = ID_W'((int'(rr_q) + i) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign cnt_inc = (det_match && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

    always_comb begin
        state_d     = state_q;
        gnt_d       = '0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        done_id_d   = done_id_q;
        match_cnt_d = match_cnt_q;
        rr_d        = rr_q;
        id_d        = id_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        cnt_d       = cnt_q;
        pattern_d   = pattern_q;
        det_clr     = 1'b0;
        det_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d     = NREQ'(1) << win;
                    id_d      = win;
                    shreg_d   = frame_arr[win];
                    bit_cnt_d = '0;
                    cnt_d     = '0;
                    det_clr   = 1'b1;
                    rr_d      = (win == ID_W'(NREQ - 1)) ? '0 : win + 1'b1;
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end else if (cfg_we) begin
                    pattern_d = cfg_pattern;
                end
            end
            SHIFT: begin
                det_en    = 1'b1;
                shreg_d   = shreg_q << 1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                // The first SHIFT cycle still sees the cleared detector output.
                if (bit_cnt_q != '0) cnt_d = cnt_inc;
                if (bit_cnt_q == BC_W'(FRAME_W - 1)) state_d = DRAIN;
            end
            DRAIN: begin
                cnt_d       = cnt_inc;
                done_d      = 1'b1;
                done_id_d   = id_q;
                match_cnt_d = cnt_inc;
                state_d     = REPORT;
            end
            REPORT: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= '0;
            match_cnt_q <= '0;
            rr_q        <= '0;
            id_q        <= '0;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            cnt_q       <= '0;
            pattern_q   <= PAT_W'(DEFAULT_PATTERN);
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            done_id_q   <= done_id_d;
            match_cnt_q <= match_cnt_d;
            rr_q        <= rr_d;
            id_q        <= id_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            cnt_q       <= cnt_d;
            pattern_q   <= pattern_d;
        end
    end

    pat_det_moore #(.PAT_W(PAT_W)) u_det (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (det_clr),
        .en      (det_en),
        .din     (shreg_q[FRAME_W-1]),
        .pattern (pattern_q),
        .match   (det_match)
    );

    assign gnt       = gnt_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign done_id   = done_id_q;
    assign match_cnt = match_cnt_q;
endmodule

// File: tb/tb_seq_det_scheduler.sv
// Bench for seq_det_scheduler: job-level reference model, per-cycle compare, directed scenarios.
module tb_seq_det_scheduler;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [31:0] frame;
    logic [3:0]  gnt;
    logic        cfg_we;
    logic [3:0]  cfg_pattern;
    logic        busy, done;
    logic [1:0]  done_id;
    logic [2:0]  match_cnt;

    logic [1:0]  req16;
    logic [31:0] frame16;
    logic [1:0]  gnt16;
    logic        cfg_we16;
    logic [3:0]  cfg_pat16;
    logic        busy16, done16;
    logic [0:0]  done_id16;
    logic [2:0]  match_cnt16;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    seq_det_scheduler #(.NREQ(4), .FRAME_W(8), .PAT_W(4), .CNT_W(3)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .frame(frame), .gnt(gnt),
        .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .busy(busy), .done(done),
        .done_id(done_id), .match_cnt(match_cnt)
    );

    seq_det_scheduler #(.NREQ(2), .FRAME_W(16), .PAT_W(4), .CNT_W(3)) dut16 (
        .clk(clk), .reset_n(reset_n), .req(req16), .frame(frame16), .gnt(gnt16),
        .cfg_we(cfg_we16), .cfg_pattern(cfg_pat16), .busy(busy16), .done(done16),
        .done_id(done_id16), .match_cnt(match_cnt16)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Count of PAT_W=4 windows in the MSB-first bit stream equal to pat.
    function automatic int raw_matches(input logic [31:0] f, input int fw, input logic [3:0] pat);
        int c = 0;
        logic [3:0] w;
        for (int e = 3; e < fw; e++) begin
            w = {f[fw-1-(e-3)], f[fw-1-(e-2)], f[fw-1-(e-1)], f[fw-1-e]};
            if (w == pat) c++;
        end
        return c;
    endfunction

    function automatic int sat7(input int c);
        return (c > 7) ? 7 : c;
    endfunction

    // Job-level model: a job occupies cycles 0..FRAME_W+1 after its grant edge.
    int         m_t = -1;
    int         m_rr, m_id, m_cnt, m_j;
    bit         m_found;
    logic [3:0] m_pat;
    logic [3:0] exp_gnt;
    logic       exp_busy, exp_done;
    logic [1:0] exp_id;
    logic [2:0] exp_cnt;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_t = -1; m_rr = 0; m_pat = 4'b1101;
            exp_gnt = 0; exp_busy = 0; exp_done = 0; exp_id = 0; exp_cnt = 0;
        end else begin
            exp_gnt  = 0;
            exp_done = 0;
            if (m_t < 0) begin
                m_found = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    m_j = (m_rr + i) % 4;
                    if (!m_found && req[m_j]) begin
                        m_found = 1'b1;
                        m_id    = m_j;
                    end
                end
                if (m_found) begin
                    m_cnt   = sat7(raw_matches({24'h0, frame[m_id*8 +: 8]}, 8, m_pat));
                    m_rr    = (m_id + 1) % 4;
                    m_t     = 0;
                    exp_gnt = 4'(1 << m_id);
                end else if (cfg_we) begin
                    m_pat = cfg_pattern;
                end
            end else begin
                m_t++;
                if (m_t == 10) m_t = -1;
                else if (m_t == 9) begin
                    exp_done = 1'b1;
                    exp_id   = 2'(m_id);
                    exp_cnt  = 3'(m_cnt);
                end
            end
            exp_busy = (m_t >= 0);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_gnt", gnt, exp_gnt);
            chk("cyc_busy", busy, exp_busy);
            chk("cyc_done", done, exp_done);
            chk("cyc_done_id", done_id, exp_id);
            chk("cyc_match_cnt", match_cnt, exp_cnt);
        end
    end

    int gnt_ids[$];
    int gnt_cycs[$];
    int done_cycs[$];
    int g16_cyc = -1;
    int d16_cyc = -1;

    always @(negedge clk) begin
        if (gnt != 0) begin
            for (int i = 0; i < 4; i++) if (gnt[i]) begin
                gnt_ids.push_back(i);
                gnt_cycs.push_back(cyc);
            end
        end
        if (done) done_cycs.push_back(cyc);
        if (gnt16 != 0) g16_cyc = cyc;
        if (done16) d16_cyc = cyc;
    end

    task automatic clear_log();
        gnt_ids.delete();
        gnt_cycs.delete();
        done_cycs.delete();
    endtask

    task automatic wait_gnt(input int bound);
        int n = 0;
        do begin @(negedge clk); n++; end while (gnt == 0 && n < bound);
        #1;
        chk("wait_gnt", gnt != 0, 1);
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        do begin @(negedge clk); n++; end while (!done && n < bound);
        #1;
        chk("wait_done", done, 1);
    endtask

    task automatic cfg_write(input logic [3:0] pat);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_pattern = pat;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic run_job(input int id, input logic [7:0] fv, input bit cfg_mid);
        @(posedge clk); #1;
        frame[id*8 +: 8] = fv;
        req[id] = 1'b1;
        wait_gnt(20);
        @(posedge clk); #1;
        req[id] = 1'b0;
        if (cfg_mid) begin
            cfg_we = 1'b1; cfg_pattern = 4'b0000;
            @(posedge clk); #1;
            cfg_we = 1'b0;
        end
        wait_done(20);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        reset_n = 1'b0; req = '0; frame = '0; cfg_we = 1'b0; cfg_pattern = '0;
        req16 = '0; frame16 = '0; cfg_we16 = 1'b0; cfg_pat16 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_done_id", done_id, 0);
        chk("rst_match_cnt", match_cnt, 0);
        chk("rst_busy16", busy16, 0);
        chk_en = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Model pins against hand-counted windows.
        chk("pin_da_1101", raw_matches(32'hDA, 8, 4'b1101), 2);
        chk("pin_ff_1111", raw_matches(32'hFF, 8, 4'b1111), 5);
        chk("pin_ffff_1111", raw_matches(32'hFFFF, 16, 4'b1111), 13);

        clear_log();
        run_job(0, 8'b1101_1010, 1'b0);
        chk("t1_done_id", done_id, 0);
        chk("t1_match_cnt", match_cnt, 2);
        chk("t1_latency", (gnt_cycs.size() > 0 && done_cycs.size() > 0) ? done_cycs[0] - gnt_cycs[0] : -1, 9);

        cfg_write(4'b1111);
        run_job(0, 8'hFF, 1'b0);
        chk("t2_overlap", match_cnt, 5);

        run_job(0, 8'h00, 1'b1);
        chk("t4_cfg_in_shift", match_cnt, 0);
        cfg_write(4'b0000);
        run_job(0, 8'h00, 1'b0);
        chk("t4_cfg_in_idle", match_cnt, 5);

        do_reset();
        clear_log();
        @(posedge clk); #1;
        frame = 32'hB6_00_FF_DA;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) wait_gnt(20);
        @(posedge clk); #1;
        req = 4'b0000;
        wait_done(20);
        chk("t3_gnt_count", gnt_ids.size(), 5);
        if (gnt_ids.size() >= 5) begin
            for (int k = 0; k < 5; k++) chk("t3_order", gnt_ids[k], k % 4);
            for (int k = 0; k < 4; k++) chk("t3_spacing", gnt_cycs[k+1] - gnt_cycs[k], 11);
        end

        @(posedge clk); #1;
        frame[23:16] = 8'b1101_1010;
        req = 4'b0100;
        cfg_we = 1'b1; cfg_pattern = 4'b0000;
        wait_gnt(20);
        chk("t6_gnt", gnt, 4'b0100);
        @(posedge clk); #1;
        req = 4'b0000; cfg_we = 1'b0;
        wait_done(20);
        chk("t6_done_id", done_id, 2);
        chk("t6_pattern_kept", match_cnt, 2);

        @(posedge clk); #1;
        frame[23:16] = 8'hFF;
        req = 4'b0100;
        wait_gnt(20);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0; req = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        n0 = done_cycs.size();
        repeat (15) @(negedge clk);
        chk("t5_no_done", done_cycs.size(), n0);
        @(posedge clk); #1;
        req = 4'b0110;
        wait_gnt(20);
        chk("t5_gnt_after_reset", gnt, 4'b0010);
        @(posedge clk); #1;
        req = 4'b0000;
        wait_done(20);
        chk("t5_done_id", done_id, 1);

        @(posedge clk); #1;
        cfg_we16 = 1'b1; cfg_pat16 = 4'b1111;
        @(posedge clk); #1;
        cfg_we16 = 1'b0;
        frame16[15:0] = 16'hFFFF;
        req16 = 2'b01;
        n0 = 0;
        do begin @(negedge clk); n0++; end while (gnt16 == 0 && n0 < 20);
        chk("t2w_gnt16", gnt16, 2'b01);
        @(posedge clk); #1;
        req16 = 2'b00;
        n0 = 0;
        do begin @(negedge clk); n0++; end while (!done16 && n0 < 40);
        #1;
        chk("t2w_done16", done16, 1);
        chk("t2w_saturate", match_cnt16, 7);
        chk("t2w_done_id16", done_id16, 0);
        chk("t2w_latency", d16_cyc - g16_cyc, 17);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
